// File: rtl/snoop_responder.sv
// snoop_responder
//   Snooping coherence responder for a 4-block cache owned by processor
//   PROC_ID. It accepts one bus transaction at a time and looks up the
//   addressed block. Snoops that hit an exclusive block force a writeback
//   that lasts WB_CYCLES cycles. The resulting block state is committed
//   when the transaction leaves COMMIT. The local requester can also
//   write block states directly.
//
// Ports
//   clock, reset_n         clock; asynchronous active-low reset
//   bus_valid/msg/src/idx  snooped transaction (msg: 000 none, 001 read miss,
//                          010 write miss, 011 invalidate, 1xx reserved)
//   bus_ready              transaction accepted this cycle if bus_valid
//   cpu_wr_en/index/state  local block-state write (00 I, 01 S, 10 E, 11 bad)
//   line_state             block i state in bits [2i+1:2i]
//   writeback_block        snoop-forced writeback in progress
//   wb_index               block being written back (0 when idle)
//   abort_access           pulse: requester must retry after the writeback
//   snoop_done             pulse: transaction committed
//   cpu_wr_conflict        pulse: local write dropped (block busy)
//   proto_error            sticky protocol-violation flag
module snoop_responder #(
  parameter logic [1:0]  PROC_ID   = 2'b00,
  parameter int unsigned WB_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       bus_valid,
  input  logic [2:0] bus_msg,
  input  logic [1:0] bus_src,
  input  logic [1:0] bus_index,
  output logic       bus_ready,
  input  logic       cpu_wr_en,
  input  logic [1:0] cpu_wr_index,
  input  logic [1:0] cpu_wr_state,
  output logic [7:0] line_state,
  output logic       writeback_block,
  output logic [1:0] wb_index,
  output logic       abort_access,
  output logic       snoop_done,
  output logic       cpu_wr_conflict,
  output logic       proto_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WB     = 2'b01,
    COMMIT = 2'b10
  } state_t;

  localparam logic [2:0] MSG_RD_MISS = 3'b001;
  localparam logic [2:0] MSG_WR_MISS = 3'b010;
  localparam logic [2:0] MSG_INVAL   = 3'b011;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_BAD = 2'b11;

  state_t     state, state_nx;
  logic [1:0] blk [4];

  // The snoop decision is resolved at acceptance. Only its outcome is kept,
  // not the raw message and source.
  logic [1:0] lat_index;
  logic [1:0] lat_final;
  logic       lat_change;
  logic [3:0] wb_cnt;

  logic       accept;
  logic       relevant;
  logic [1:0] cur_state;
  logic [1:0] dec_final;
  logic       dec_wb;
  logic       dec_err;
  logic       busy_hit;
  logic       cpu_apply;

  // Snoop decision based on the registered state of the addressed block.
  always_comb begin
    accept    = bus_valid && (state == IDLE);
    cur_state = blk[bus_index];
    relevant  = (bus_src != PROC_ID) &&
                ((bus_msg == MSG_RD_MISS) || (bus_msg == MSG_WR_MISS) ||
                 (bus_msg == MSG_INVAL));
    dec_final = cur_state;
    dec_wb    = 1'b0;
    dec_err   = 1'b0;
    if (relevant) begin
      case (cur_state)
        ST_S: begin
          if (bus_msg != MSG_RD_MISS) dec_final = ST_I;
        end
        ST_E: begin
          case (bus_msg)
            MSG_RD_MISS: begin
              dec_final = ST_S;
              dec_wb    = 1'b1;
            end
            MSG_WR_MISS: begin
              dec_final = ST_I;
              dec_wb    = 1'b1;
            end
            default: begin
              // Invalidate on an exclusive block: another owner cannot exist.
              dec_final = ST_I;
              dec_err   = 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  // Local writes to the block held by an in-flight snoop are dropped, so the
  // commit in COMMIT never collides with a local write to the same block.
  always_comb begin
    busy_hit  = (state != IDLE) && (cpu_wr_index == lat_index);
    cpu_apply = cpu_wr_en && !busy_hit && (cpu_wr_state != ST_BAD);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    bus_ready       = 1'b0;
    writeback_block = 1'b0;
    wb_index        = '0;
    snoop_done      = 1'b0;
    case (state)
      IDLE: begin
        bus_ready = 1'b1;
        if (accept) state_nx = dec_wb ? WB : COMMIT;
      end
      WB: begin
        writeback_block = 1'b1;
        wb_index        = lat_index;
        if (wb_cnt <= 4'd1) state_nx = COMMIT;
      end
      COMMIT: begin
        snoop_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) blk[i] <= '0;
      lat_index       <= '0;
      lat_final       <= '0;
      lat_change      <= 1'b0;
      wb_cnt          <= '0;
      abort_access    <= 1'b0;
      cpu_wr_conflict <= 1'b0;
      proto_error     <= 1'b0;
    end else begin
      abort_access    <= accept && dec_wb;
      cpu_wr_conflict <= cpu_wr_en && busy_hit;
      if ((cpu_wr_en && (cpu_wr_state == ST_BAD)) || (accept && dec_err))
        proto_error <= 1'b1;

      if (accept) begin
        lat_index  <= bus_index;
        lat_final  <= dec_final;
        lat_change <= (dec_final != cur_state);
        wb_cnt     <= dec_wb ? 4'(WB_CYCLES) : '0;
      end else if ((state == WB) && (wb_cnt != '0)) begin
        wb_cnt <= wb_cnt - 4'd1;
      end

      if (cpu_apply) blk[cpu_wr_index] <= cpu_wr_state;
      // Only changed blocks are rewritten, so that a local write accepted on
      // the same edge as a no-op snoop is not overwritten with a stale value.
      if ((state == COMMIT) && lat_change) blk[lat_index] <= lat_final;
    end
  end

  always_comb begin
    line_state = '0;
    for (int unsigned i = 0; i < 4; i++) line_state[2*i +: 2] = blk[i];
  end

endmodule
